// File: rtl/alu_bitserial_seq.sv
// Bit-serial ALU sequencer: drives the per-bit operand mux and ripples a sum LSB-first over WIDTH cycles.
// Optional: define ALU_SEQ_OVERFLOW_FLAG_EN to add the signed-overflow output.
module alu_bitserial_seq #(
  parameter int                   WIDTH       = 8,
  parameter int                   NUM_OPTIONS = 6,
  parameter int                   SIZE_SEL    = 2,
  parameter logic [NUM_OPTIONS:0] CIN_MASK    = 7'b0100101
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [SIZE_SEL:0]   opcode,
  input  logic [WIDTH-1:0]    a_in,
  input  logic [WIDTH-1:0]    b_in,
  output logic [SIZE_SEL:0]   opsel,
  output logic                b_bit,
  input  logic                m_out_bit,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [WIDTH-1:0]    result,
  output logic                carry_out,
  output logic                err
`ifdef ALU_SEQ_OVERFLOW_FLAG_EN
  ,
  output logic                overflow
`endif
);

  localparam int SEL_W = SIZE_SEL + 1;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [SIZE_SEL:0] MAX_OP  = SEL_W'(NUM_OPTIONS);
  localparam logic [CNT_W-1:0]  LAST_CT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sh, b_sh;
  logic [CNT_W-1:0]   count;
  logic               carry;
  logic               op_bad;
  logic               last;
  logic               s_bit, c_nxt;

  function automatic logic sum3(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  assign op_bad    = (opcode > MAX_OP);
  assign last      = (count == LAST_CT);
  assign op_ready  = (state == IDLE);
  assign res_valid = (state == DONE);
  // b_bit feeds the external mux combinationally; its output returns as m_out_bit in the same cycle
  assign b_bit     = (state == SHIFT) ? b_sh[0] : 1'b0;
  assign s_bit     = sum3(a_sh[0], m_out_bit, carry);
  assign c_nxt     = maj3(a_sh[0], m_out_bit, carry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (op_valid) state_nxt = op_bad ? DONE : SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      count     <= '0;
      carry     <= 1'b0;
      opsel     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      err       <= 1'b0;
`ifdef ALU_SEQ_OVERFLOW_FLAG_EN
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            result    <= '0;
            carry_out <= 1'b0;
            count     <= '0;
            err       <= op_bad;
`ifdef ALU_SEQ_OVERFLOW_FLAG_EN
            overflow  <= 1'b0;
`endif
            // A bad opcode leaves the shift path untouched and parks the mux on input 0
            if (op_bad) begin
              opsel <= '0;
            end else begin
              a_sh  <= a_in;
              b_sh  <= b_in;
              opsel <= opcode;
              carry <= CIN_MASK[opcode];
            end
          end
        end
        SHIFT: begin
          carry  <= c_nxt;
          result <= {s_bit, result[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          count  <= count + 1'b1;
          if (last) begin
            carry_out <= c_nxt;
`ifdef ALU_SEQ_OVERFLOW_FLAG_EN
            overflow  <= carry ^ c_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
